// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-unit bus. It carries the ID-stage operand and destination info, the MDU
// controls and flush in from the pipeline, and the stall and MDU status back out.
interface hazard_stall_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [1:0]  id_rs_tuse;
    logic [1:0]  id_rt_tuse;
    logic [4:0]  id_dst;
    logic [1:0]  id_tnew;
    logic        id_mdu_start;
    logic        id_mdu_div;
    logic        id_mdu_use;
    logic        flush;
    logic        stall;
    logic        mdu_busy;
    logic [3:0]  mdu_cnt;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_rs_tuse, id_rt_tuse, id_dst, id_tnew,
        output id_mdu_start, id_mdu_div, id_mdu_use, flush,
        input  stall, mdu_busy, mdu_cnt, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_rs_tuse, id_rt_tuse, id_dst, id_tnew,
        input  id_mdu_start, id_mdu_div, id_mdu_use, flush,
        output stall, mdu_busy, mdu_cnt, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Tuse/Tnew hazard unit. A two-entry EX/MEM scoreboard and an MDU occupancy counter
// decide the ID-stage stall in the same cycle; a saturating counter logs stall cycles.
module hazard_stall_ctrl (
    input  logic                 clk,
    input  logic                 reset_n,
    hazard_stall_ctrl_if.slave   bus
);
    localparam logic [3:0] MULT_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT  = 4'd10;

    logic [4:0]  e_dst_r;
    logic [1:0]  e_tnew_r;
    logic [4:0]  m_dst_r;
    logic [1:0]  m_tnew_r;
    logic [3:0]  mdu_cnt_r;
    logic        mdu_busy_r;
    logic [31:0] stall_cycles_r;

    logic        rs_haz_s;
    logic        rt_haz_s;
    logic        mdu_haz_s;
    logic        stall_s;
    logic        issue_s;
    logic [3:0]  mdu_cnt_nxt_s;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // The operand is late when a producer in EX or MEM still needs more cycles than the consumer can wait.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_dst,
        input logic [1:0] e_tnew,
        input logic [4:0] m_dst,
        input logic [1:0] m_tnew
    );
        logic e_hit;
        logic m_hit;
        e_hit = (e_dst == src) && (e_tnew > tuse);
        m_hit = (m_dst == src) && (m_tnew > tuse);
        return (tuse != 2'd3) && (src != 5'd0) && (e_hit || m_hit);
    endfunction

    // Same-cycle stall decision; a flush or an active reset overrides every hazard.
    always_comb begin
        rs_haz_s  = src_hazard(bus.id_rs, bus.id_rs_tuse, e_dst_r, e_tnew_r, m_dst_r, m_tnew_r);
        rt_haz_s  = src_hazard(bus.id_rt, bus.id_rt_tuse, e_dst_r, e_tnew_r, m_dst_r, m_tnew_r);
        mdu_haz_s = bus.id_mdu_use && (mdu_cnt_r != 4'd0);
        stall_s   = reset_n && (rs_haz_s || rt_haz_s || mdu_haz_s) && !bus.flush;
        issue_s   = bus.id_mdu_start && !stall_s && !bus.flush;
    end

    // Next MDU occupancy: an accepted issue reloads the counter, otherwise it counts down to zero.
    always_comb begin
        mdu_cnt_nxt_s = mdu_cnt_r;
        if (issue_s) begin
            mdu_cnt_nxt_s = bus.id_mdu_div ? DIV_LAT : MULT_LAT;
        end else if (mdu_cnt_r != 4'd0) begin
            mdu_cnt_nxt_s = mdu_cnt_r - 4'd1;
        end else begin
            mdu_cnt_nxt_s = 4'd0;
        end
    end

    // Scoreboard advance, MDU counter and stall statistics.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            e_dst_r        <= 5'd0;
            e_tnew_r       <= 2'd0;
            m_dst_r        <= 5'd0;
            m_tnew_r       <= 2'd0;
            mdu_cnt_r      <= 4'd0;
            mdu_busy_r     <= 1'b0;
            stall_cycles_r <= 32'd0;
        end else begin
            if (stall_s || bus.flush) begin
                e_dst_r  <= 5'd0;
                e_tnew_r <= 2'd0;
            end else begin
                e_dst_r  <= bus.id_dst;
                e_tnew_r <= bus.id_tnew;
            end
            m_dst_r    <= e_dst_r;
            m_tnew_r   <= sat_dec(e_tnew_r);
            mdu_cnt_r  <= mdu_cnt_nxt_s;
            mdu_busy_r <= (mdu_cnt_nxt_s != 4'd0);
            if (stall_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
        end
    end

    assign bus.stall        = stall_s;
    assign bus.mdu_busy     = mdu_busy_r;
    assign bus.mdu_cnt      = mdu_cnt_r;
    assign bus.stall_cycles = stall_cycles_r;
endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port reset_n, input, 1 bit: synchronous active-low reset.
REQ-004 The block SHALL have ports id_rs and id_rt, input, 5 bits each: source registers of the ID instruction.
REQ-005 The block SHALL have ports id_rs_tuse and id_rt_tuse, input, 2 bits each: cycles until the operand is needed (0=ID branch compare, 1=EX, 2=MEM store data, 3=unused).
REQ-006 The block SHALL have port id_dst, input, 5 bits: destination register of the ID instruction (0=no write).
REQ-007 The block SHALL have port id_tnew, input, 2 bits: cycles after EX entry until the result is forwardable (ALU/link=1, load=2, no-write=0).
REQ-008 The block SHALL have ports id_mdu_start (1 bit, mult/div issue), id_mdu_div (1 bit, 1=div) and id_mdu_use (1 bit, any HI/LO or MDU instruction), all inputs.
REQ-009 The block SHALL have port flush, input, 1 bit: kill the ID instruction (exception/redirect).
REQ-010 The block SHALL have port stall, output, 1 bit: freeze PC and IF/ID, insert bubble into ID/EX.
REQ-011 The block SHALL have ports mdu_busy (1 bit) and mdu_cnt (4 bits), outputs: MDU occupancy and remaining cycles.
REQ-012 The block SHALL have port stall_cycles, output, 32 bits: saturating count of stall cycles.

Function
REQ-013 The block SHALL hold internal scoreboard entries E = {dst[4:0], tnew[1:0]} and M = {dst, tnew}, mirroring the EX and MEM stages.
REQ-014 The block SHALL compute a data hazard per source s in {rs, rt} when tuse_s != 3, s != 0, and either (E.dst == s and E.tnew > tuse_s) or (M.dst == s and M.tnew > tuse_s).
REQ-015 The block SHALL compute an MDU hazard = id_mdu_use && (mdu_cnt != 0).
REQ-016 The block SHALL drive stall combinationally = (rs hazard | rt hazard | MDU hazard) && !flush, with the same-cycle decision (zero latency).
REQ-017 On each clock with !stall && !flush, E SHALL load {id_dst, id_tnew}.
REQ-018 On each clock with stall or flush, E SHALL load the bubble {0, 0}.
REQ-019 On every clock, M SHALL load {E.dst, sat_dec(E.tnew)}, where sat_dec(0)=0 and sat_dec(n)=n-1.
REQ-020 An MDU issue SHALL be accepted when id_mdu_start && !stall && !flush; on acceptance mdu_cnt SHALL load 5 (mult) or 10 (div).
REQ-021 Otherwise, when mdu_cnt != 0, mdu_cnt SHALL decrement by 1 per clock; at 0 it SHALL hold.
REQ-022 Issue while mdu_cnt != 0 cannot occur, because id_mdu_use covers start and stalls it; mdu_busy SHALL equal (mdu_cnt != 0).
REQ-023 stall_cycles SHALL increment when stall=1 and saturate at 32'hFFFF_FFFF.
REQ-024 flush and hazard in the same cycle: flush SHALL win; stall=0 and E SHALL take a bubble.
REQ-025 When E and M both match the same source, the source SHALL stall if either entry satisfies REQ-014.

Reset
REQ-026 While reset_n=0 at a rising edge, E, M, mdu_cnt and stall_cycles SHALL all load 0.
REQ-027 While reset_n=0, stall SHALL be forced to 0.
REQ-028 Reset asserted mid-MDU-operation or mid-stall SHALL abort the operation/stall with no residual state.

Verification
REQ-029 Load-use: load to $8 (id_tnew=2), then ID add with rs=$8, tuse=1 -> stall=1 exactly one cycle, then 0; stall_cycles=1.
REQ-030 ALU-branch: ALU to $9 (tnew=1), then beq with rs=$9, tuse=0 -> stall 1 cycle; load-to-beq -> stall 2 cycles.
REQ-031 Register zero/no-use: load to $0 followed by a user of $0, and tuse=3 with a matching register -> stall=0.
REQ-032 MDU: div issued, next instruction mflo (id_mdu_use=1) -> mdu_cnt 10..1 with stall=1 for 10 cycles; mult gives 5 cycles.
REQ-033 Flush priority: flush=1 during a load-use hazard -> stall=0, E={0,0} next cycle, and stall_cycles unchanged.
REQ-034 Reset mid-div at mdu_cnt=6 -> after one reset_n=0 edge, mdu_cnt=0, mdu_busy=0, stall=0 and stall_cycles=0.
